adder_error_monitor: RTL and testbench

Sequential error-statistics collector that sits directly downstream of an approximate 16-bit adder under evaluation. Each accepted sample carries the operands and the approximate 17-bit sum. The block recomputes the exact sum, forms the absolute error, and accumulates campaign metrics over a programmed number of samples:
- error count
- sum of absolute errors
- maximum absolute error
- optional Hamming distance

It raises `done` when the campaign has drained.

---
 rtl/adder_error_monitor.sv | 240 ++++++++++++++++++++++++
 tb/tb_adder_error_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_error_monitor.sv
// adder_error_monitor
//   Error-statistics collector for an approximate W-bit adder. Each accepted
//   sample (op_a, op_b, approx_sum) is compared with the exact sum; the block
//   accumulates error count, sum of absolute errors, maximum absolute error
//   and, optionally, the summed Hamming distance over a programmed number of
//   samples, then raises done.
//
//   Optional feature macro: ERRMON_HAMMING_EN (adds popcount logic and ham_sum).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, target     campaign start pulse and sample count (sampled on start)
//   in_valid/in_ready sample handshake
//   op_a, op_b        operands
//   approx_sum        W+1-bit result from the adder under test
//   busy, done        campaign in progress / results final
//   sample_cnt        samples accepted
//   err_cnt           samples with nonzero error
//   abs_err_sum       saturating sum of |exact - approx|
//   max_abs_err       largest |exact - approx|
//   ham_sum           saturating sum of popcount(exact ^ approx) (optional)

module adder_error_monitor #(
    parameter int unsigned W     = 16,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic [W:0]       approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] abs_err_sum,
    output logic [W:0]       max_abs_err
`ifdef ERRMON_HAMMING_EN
    ,
    output logic [ACC_W-1:0] ham_sum
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef ERRMON_HAMMING_EN
    localparam int unsigned POP_W = $clog2(W + 2);
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] abs_err_sum_q, abs_err_sum_d;
    logic [W:0]       max_abs_err_q, max_abs_err_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [W:0]       s1_abs_q, s1_abs_d;
    logic             s1_err_q, s1_err_d;

`ifdef ERRMON_HAMMING_EN
    logic [POP_W-1:0] s1_pop_q, s1_pop_d;
    logic [ACC_W-1:0] ham_sum_q, ham_sum_d;
    logic [W:0]       xor_c;
    logic [POP_W-1:0] pop_c;
    logic [ACC_W:0]   ham_ext_c;
`endif

    logic             handshake_c;
    logic [W:0]       exact_c;
    logic signed [W+1:0] diff_c;
    logic [W:0]       abs_c;
    logic [ACC_W:0]   abs_ext_c;

    // Per-sample arithmetic on the incoming operands
    always_comb begin
        exact_c = (W+1)'(op_a) + (W+1)'(op_b);
        diff_c  = $signed({1'b0, exact_c}) - $signed({1'b0, approx_sum});
        // |diff| never exceeds 2^(W+1)-1, so the truncation is lossless
        abs_c   = diff_c[W+1] ? (W+1)'(-diff_c) : (W+1)'(diff_c);
    end

`ifdef ERRMON_HAMMING_EN
    // Popcount of exact XOR approx
    always_comb begin
        xor_c = exact_c ^ approx_sum;
        pop_c = '0;
        for (int i = 0; i <= int'(W); i++) begin
            pop_c = pop_c + POP_W'(xor_c[i]);
        end
    end
`endif

    assign handshake_c = in_valid && in_ready_q;

    // Next-state, pipeline and accumulator logic
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        sample_cnt_d  = sample_cnt_q;
        err_cnt_d     = err_cnt_q;
        abs_err_sum_d = abs_err_sum_q;
        max_abs_err_d = max_abs_err_q;
        s1_valid_d    = 1'b0;
        s1_abs_d      = s1_abs_q;
        s1_err_d      = s1_err_q;
        abs_ext_c     = {1'b0, abs_err_sum_q} + (ACC_W+1)'(s1_abs_q);
`ifdef ERRMON_HAMMING_EN
        s1_pop_d      = s1_pop_q;
        ham_sum_d     = ham_sum_q;
        ham_ext_c     = {1'b0, ham_sum_q} + (ACC_W+1)'(s1_pop_q);
`endif

        if (start) begin
            // Restart: clear statistics, flush the pipeline, reload target
            target_d      = target;
            sample_cnt_d  = '0;
            err_cnt_d     = '0;
            abs_err_sum_d = '0;
            max_abs_err_d = '0;
            s1_valid_d    = 1'b0;
`ifdef ERRMON_HAMMING_EN
            ham_sum_d     = '0;
`endif
            state_d       = (target != '0) ? ST_RUN : ST_DONE;
        end else begin
            // Stage 1 capture at handshake
            if (handshake_c) begin
                s1_valid_d = 1'b1;
                s1_abs_d   = abs_c;
                s1_err_d   = (abs_c != '0);
`ifdef ERRMON_HAMMING_EN
                s1_pop_d   = pop_c;
`endif
                if (sample_cnt_q != '1) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                end
            end

            // Stage 2 accumulate, all saturating
            if (s1_valid_q) begin
                if (s1_err_q && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                abs_err_sum_d = abs_ext_c[ACC_W] ? '1 : abs_ext_c[ACC_W-1:0];
                if (s1_abs_q > max_abs_err_q) begin
                    max_abs_err_d = s1_abs_q;
                end
`ifdef ERRMON_HAMMING_EN
                ham_sum_d = ham_ext_c[ACC_W] ? '1 : ham_ext_c[ACC_W-1:0];
`endif
            end

            unique case (state_q)
                ST_RUN: begin
                    if (handshake_c && (sample_cnt_d == target_q)) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Stage 2 works in the same cycle stage 1 holds a sample,
                    // so an empty stage 1 means both stages have drained
                    if (!s1_valid_q) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        in_ready_d = (state_d == ST_RUN) && (sample_cnt_d < target_d);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    // State and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            sample_cnt_q  <= '0;
            err_cnt_q     <= '0;
            abs_err_sum_q <= '0;
            max_abs_err_q <= '0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_abs_q      <= '0;
            s1_err_q      <= 1'b0;
`ifdef ERRMON_HAMMING_EN
            s1_pop_q      <= '0;
            ham_sum_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            sample_cnt_q  <= sample_cnt_d;
            err_cnt_q     <= err_cnt_d;
            abs_err_sum_q <= abs_err_sum_d;
            max_abs_err_q <= max_abs_err_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            s1_valid_q    <= s1_valid_d;
            s1_abs_q      <= s1_abs_d;
            s1_err_q      <= s1_err_d;
`ifdef ERRMON_HAMMING_EN
            s1_pop_q      <= s1_pop_d;
            ham_sum_q     <= ham_sum_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sample_cnt  = sample_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign abs_err_sum = abs_err_sum_q;
    assign max_abs_err = max_abs_err_q;
`ifdef ERRMON_HAMMING_EN
    assign ham_sum     = ham_sum_q;
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed testbench for adder_error_monitor (ACC_W reduced to 18 so the
// saturation case is reachable in a few samples).

module tb_adder_error_monitor;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned ACC_W = 18;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] target;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W:0]       approx_sum;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [ACC_W-1:0] abs_err_sum;
    logic [W:0]       max_abs_err;
`ifdef ERRMON_HAMMING_EN
    logic [ACC_W-1:0] ham_sum;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    adder_error_monitor #(
        .W     (W),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .target      (target),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .approx_sum  (approx_sum),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .abs_err_sum (abs_err_sum),
        .max_abs_err (max_abs_err)
`ifdef ERRMON_HAMMING_EN
        ,
        .ham_sum     (ham_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] tgt);
        start  = 1'b1;
        target = tgt;
        tick();
        start  = 1'b0;
    endtask

    // Present one sample and return one cycle after its handshake
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] s);
        op_a       = a;
        op_b       = b;
        approx_sum = s;
        in_valid   = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            tick();
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        check({tag, "_abs_sum"}, 64'(abs_err_sum), 64'd0);
        check({tag, "_max"}, 64'(max_abs_err), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        target     = '0;
        in_valid   = 1'b1;
        op_a       = '0;
        op_b       = '0;
        approx_sum = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Idle after reset with a sample offered
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check_cleared("rst");
`ifdef ERRMON_HAMMING_EN
        check("rst_ham", 64'(ham_sum), 64'd0);
`endif
        in_valid = 1'b0;

        // Four exact samples, done exactly three cycles after last handshake
        do_start(32'd4);
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_in_ready", 64'(in_ready), 64'd1);
        send(16'h1234, 16'h0FFF, 17'h02233);
        send(16'hFFFF, 16'h0001, 17'h10000);
        send(16'h0000, 16'h0000, 17'h00000);
        send(16'h8000, 16'h8000, 17'h10000);
        check("t4_done_t1", 64'(done), 64'd0);
        check("t4_busy_t1", 64'(busy), 64'd1);
        tick();
        check("t4_done_t2", 64'(done), 64'd0);
        tick();
        check("t4_done_t3", 64'(done), 64'd1);
        check("t4_busy_t3", 64'(busy), 64'd0);
        check("t4_sample_cnt", 64'(sample_cnt), 64'd4);
        check("t4_err_cnt", 64'(err_cnt), 64'd0);
        check("t4_abs_sum", 64'(abs_err_sum), 64'd0);
        check("t4_max", 64'(max_abs_err), 64'd0);

        // Two erroneous samples: under- and over-estimate
        do_start(32'd2);
        check("t2_cleared", 64'(sample_cnt), 64'd0);
        check("t2_done_cleared", 64'(done), 64'd0);
        send(16'h00FF, 16'h0001, 17'h00000);
        send(16'h0001, 16'h0001, 17'h00005);
        wait_done("t2_done");
        check("t2_sample_cnt", 64'(sample_cnt), 64'd2);
        check("t2_err_cnt", 64'(err_cnt), 64'd2);
        check("t2_abs_sum", 64'(abs_err_sum), 64'h103);
        check("t2_max", 64'(max_abs_err), 64'h100);
`ifdef ERRMON_HAMMING_EN
        // 0x100^0x000 has 1 bit set, 0x002^0x005 = 0x007 has 3 bits set
        check("t2_ham", 64'(ham_sum), 64'd4);
`endif
        // A third sample is never accepted
        op_a       = 16'h0003;
        op_b       = 16'h0003;
        approx_sum = 17'h00000;
        in_valid   = 1'b1;
        tick();
        tick();
        tick();
        check("t2_extra_in_ready", 64'(in_ready), 64'd0);
        check("t2_extra_sample_cnt", 64'(sample_cnt), 64'd2);
        check("t2_extra_abs_sum", 64'(abs_err_sum), 64'h103);
        in_valid = 1'b0;

        // Target 0 finishes the cycle after start with cleared statistics
        do_start(32'd0);
        check("t0_done", 64'(done), 64'd1);
        check("t0_busy", 64'(busy), 64'd0);
        check("t0_in_ready", 64'(in_ready), 64'd0);
        check_cleared("t0");

        // Restart mid-campaign discards in-flight work
        do_start(32'd10);
        for (int i = 0; i < 5; i++) begin
            send(16'h0001, 16'h0001, 17'h00000);
        end
        check("rs_live_sample_cnt", 64'(sample_cnt), 64'd5);
        check("rs_live_err_cnt", 64'(err_cnt), 64'd4);
        check("rs_live_abs_sum", 64'(abs_err_sum), 64'd8);
        do_start(32'd1);
        check_cleared("rs_clear");
        check("rs_in_ready", 64'(in_ready), 64'd1);
        send(16'h0010, 16'h0000, 17'h00013);
        wait_done("rs_done");
        check("rs_sample_cnt", 64'(sample_cnt), 64'd1);
        check("rs_err_cnt", 64'(err_cnt), 64'd1);
        check("rs_abs_sum", 64'(abs_err_sum), 64'd3);
        check("rs_max", 64'(max_abs_err), 64'd3);

        // Reset mid-campaign returns to reset values
        do_start(32'd10);
        for (int i = 0; i < 3; i++) begin
            send(16'h0002, 16'h0002, 17'h00000);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd0);
        check("mr_done", 64'(done), 64'd0);
        check_cleared("mr");
        tick();
        check("mr_abs_sum_after", 64'(abs_err_sum), 64'd0);
        check("mr_busy_after", 64'(busy), 64'd0);

        // Saturation of the 18-bit absolute-error accumulator
        do_start(32'd5);
        for (int i = 0; i < 3; i++) begin
            send(16'hFFFF, 16'hFFFF, 17'h00000);
        end
        check("sat_live_abs_sum", 64'(abs_err_sum), 64'h3FFFC);
        send(16'hFFFF, 16'hFFFF, 17'h00000);
        send(16'hFFFF, 16'hFFFF, 17'h00000);
        wait_done("sat_done");
        check("sat_abs_sum", 64'(abs_err_sum), 64'h3FFFF);
        check("sat_err_cnt", 64'(err_cnt), 64'd5);
        check("sat_max", 64'(max_abs_err), 64'h1FFFE);
        check("sat_sample_cnt", 64'(sample_cnt), 64'd5);
        tick();
        check("sat_hold", 64'(abs_err_sum), 64'h3FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
